dec_n_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable. It is the successor to the fixed 2-to-4 combinational decoder, adding a free-running scan mode that walks a single active output across all 2^N lines with a programmable dwell time. It sits between a control register block and multiplexed loads such as display digit selects, row strobes or chip selects.

---
 rtl/dec_pkg.sv | 24 ++
 rtl/dec_n_scan_if.sv | 35 +++
 rtl/dec_dwell_cnt.sv | 40 ++++
 rtl/dec_n_scan.sv | 117 +++++++++++
 tb/tb_dec_n_scan.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types, mode constants and one-hot helper for dec_n_scan
//
// Purpose : state encoding, mode constants and the one-hot helper used by
//           the decoder top and its dwell counter.
// Ports   : none (package).
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Wide enough for N up to 8; callers cast the result down to 2^N bits.
  localparam int ONEHOT_W = 256;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] idx);
    onehot = ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_n_scan_if.sv
// rtl/dec_n_scan_if.sv - control/output bundle between register block and decoder
//
// Purpose : groups the decoder control inputs and registered outputs.
// Signals : i_en    global enable
//           i_mode  0 = direct decode, 1 = scan
//           i_a     direct-mode select index (N bits)
//           i_dwell scan dwell cycles per line (DWELL_W bits, 0 acts as 1)
//           o_d     registered one-hot output (2^N bits)
//           o_idx   index of the active line, 0 when inactive
//           o_wrap  single-cycle pulse on the last dwell cycle of the top line
// Modports: master drives controls (register block), slave is the decoder.
interface dec_n_scan_if #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
);

  logic                 i_en;
  logic                 i_mode;
  logic [N-1:0]         i_a;
  logic [DWELL_W-1:0]   i_dwell;
  logic [(1<<N)-1:0]    o_d;
  logic [N-1:0]         o_idx;
  logic                 o_wrap;

  modport master (
    output i_en, i_mode, i_a, i_dwell,
    input  o_d, o_idx, o_wrap
  );

  modport slave (
    input  i_en, i_mode, i_a, i_dwell,
    output o_d, o_idx, o_wrap
  );

endinterface

// File: rtl/dec_dwell_cnt.sv
// rtl/dec_dwell_cnt.sv - dwell down-counter with load, zero-as-one and terminal count
//
// Purpose : counts the remaining cycles a scan line stays active.
// Ports   : clk, rst   clock, async active-high reset
//           i_load     load max(i_dwell,1)-1 on this edge
//           i_dwell    dwell value sampled at load
//           o_tc       current count is zero (last cycle of this line)
//           o_tc_next  count will be zero after the coming edge
module dec_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_tc,
  output logic               o_tc_next
);

  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_load_val;

  // A dwell of 0 behaves like 1: the line is held for a single cycle.
  assign w_load_val = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign o_tc      = (r_cnt == '0);
  // Lets the top register wrap in the same cycle the final dwell count shows.
  assign o_tc_next = i_load ? (w_load_val == '0) : (r_cnt <= DWELL_W'(1));

endmodule

// File: rtl/dec_n_scan.sv
// rtl/dec_n_scan.sv - registered N-to-2^N one-hot decoder with optional scan mode
//
// Purpose : decodes bus.i_a into a registered one-hot output, or (scan build)
//           walks a single active line across all outputs with a dwell time.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  dec_n_scan_if.slave (i_en, i_mode, i_a, i_dwell -> o_d, o_idx, o_wrap)
// Config  : DEC_SCAN_EN defined enables scan mode, dwell counter and wrap;
//           undefined gives a plain enable-gated registered decoder.
module dec_n_scan #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  dec_n_scan_if.slave   bus
);

  import dec_pkg::*;

  localparam int W = 1 << N;

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_d;
  logic [W-1:0] w_d_next;
  logic [N-1:0] r_idx;
  logic [N-1:0] w_idx_next;
  logic         r_wrap;
  logic         w_wrap_next;
  logic         w_mode;

`ifdef DEC_SCAN_EN
  logic w_load;
  logic w_tc;
  logic w_tc_next;

  assign w_mode = bus.i_mode;

  dec_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_dwell   (bus.i_dwell),
    .o_tc      (w_tc),
    .o_tc_next (w_tc_next)
  );
`else
  logic w_unused_ok;

  assign w_mode      = MODE_DIRECT;
  assign w_unused_ok = ^{bus.i_mode, bus.i_dwell};
`endif

  always_comb begin
    w_state_next = r_state;
    if (!bus.i_en) begin
      w_state_next = IDLE;
    end else if (w_mode == MODE_DIRECT) begin
      w_state_next = DIRECT;
    end else begin
      w_state_next = SCAN;
    end
  end

  always_comb begin
    w_idx_next = '0;
`ifdef DEC_SCAN_EN
    w_load     = 1'b0;
`endif
    case (w_state_next)
      DIRECT: w_idx_next = bus.i_a;
`ifdef DEC_SCAN_EN
      SCAN: begin
        // Entering scan from any other state always restarts at line 0.
        if (r_state != SCAN) begin
          w_idx_next = '0;
          w_load     = 1'b1;
        end else if (w_tc) begin
          w_idx_next = r_idx + N'(1);
          w_load     = 1'b1;
        end else begin
          w_idx_next = r_idx;
        end
      end
`endif
      default: w_idx_next = '0;
    endcase
  end

`ifdef DEC_SCAN_EN
  assign w_wrap_next = (w_state_next == SCAN) && (w_idx_next == N'(W-1)) && w_tc_next;
`else
  assign w_wrap_next = 1'b0;
`endif

  assign w_d_next = (w_state_next == IDLE) ? '0 : W'(onehot(8'(w_idx_next)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_d     <= w_d_next;
      r_idx   <= w_idx_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign bus.o_d    = r_d;
  assign bus.o_idx  = r_idx;
  assign bus.o_wrap = r_wrap;

endmodule

// File: tb/tb_dec_n_scan.sv
// tb/tb_dec_n_scan.sv - directed self-checking bench for dec_n_scan
module tb_dec_n_scan;

  localparam int N  = 2;
  localparam int DW = 8;
`ifdef DEC_SCAN_EN
  localparam bit HAS_SCAN = 1'b1;
`else
  localparam bit HAS_SCAN = 1'b0;
`endif

  // Scan with dwell=2: one full period of D, idx and wrap.
  localparam logic [3:0] SC2_D [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
  localparam logic [1:0] SC2_I [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  localparam logic [7:0] SC2_W     = 8'b1000_0000;
  // Scan with dwell of 0 or 1: one line per cycle.
  localparam logic [3:0] SC1_D [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  localparam logic [3:0] SC1_W     = 4'b1000;
  localparam logic [3:0] DIR_D [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_n_scan_if #(.N(N), .DWELL_W(DW)) bus ();

  dec_n_scan #(.N(N), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] d, input logic [1:0] idx,
                           input logic wrap);
    check({tag, "_d"},    32'(bus.o_d),    32'(d));
    check({tag, "_idx"},  32'(bus.o_idx),  32'(idx));
    check({tag, "_wrap"}, 32'(bus.o_wrap), 32'(wrap));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_en    = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_a     = 2'd0;
    bus.i_dwell = 8'd0;
    #2;
    check_out("reset", 4'h0, 2'd0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Disabled with A=11: outputs stay clear.
    bus.i_a = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("disable", 4'h0, 2'd0, 1'b0);
    end

    // Direct sweep, one cycle latency.
    bus.i_en   = 1'b1;
    bus.i_mode = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.i_a = 2'(a);
      step();
      check_out("direct", DIR_D[a], 2'(a), 1'b0);
    end

    // Scan dwell=2 entered from DIRECT, two periods.
    bus.i_a     = 2'd1;
    bus.i_mode  = 1'b1;
    bus.i_dwell = 8'd2;
    for (int i = 0; i < 16; i++) begin
      step();
      check_out("scan2",
                HAS_SCAN ? SC2_D[i%8] : 4'h2,
                HAS_SCAN ? SC2_I[i%8] : 2'd1,
                HAS_SCAN ? SC2_W[i%8] : 1'b0);
    end

    // Dwell=0 acts as dwell=1.
    bus.i_en = 1'b0;
    step();
    check_out("scan0_idle", 4'h0, 2'd0, 1'b0);
    bus.i_en    = 1'b1;
    bus.i_dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_out("scan0",
                HAS_SCAN ? SC1_D[i%4] : 4'h2,
                HAS_SCAN ? 2'(i%4) : 2'd1,
                HAS_SCAN ? SC1_W[i%4] : 1'b0);
    end

    // Drop en for one cycle at idx=2, then re-enable.
    bus.i_en = 1'b0;
    step();
    check_out("int_idle", 4'h0, 2'd0, 1'b0);
    bus.i_en    = 1'b1;
    bus.i_dwell = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("int_run",
                HAS_SCAN ? SC1_D[i] : 4'h2,
                HAS_SCAN ? 2'(i) : 2'd1, 1'b0);
    end
    bus.i_en = 1'b0;
    step();
    check_out("int_off", 4'h0, 2'd0, 1'b0);
    bus.i_en = 1'b1;
    step();
    check_out("int_reen", HAS_SCAN ? 4'h1 : 4'h2, HAS_SCAN ? 2'd0 : 2'd1, 1'b0);
    bus.i_mode = 1'b0;
    bus.i_a    = 2'd3;
    step();
    check_out("int_to_dir", 4'h8, 2'd3, 1'b0);

    // Async reset between edges at idx=3.
    bus.i_a     = 2'd1;
    bus.i_mode  = 1'b1;
    bus.i_dwell = 8'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("arst_run",
                HAS_SCAN ? SC1_D[i] : 4'h2,
                HAS_SCAN ? 2'(i) : 2'd1,
                HAS_SCAN ? SC1_W[i] : 1'b0);
    end
    #3;
    rst = 1'b1;
    #1;
    check_out("arst_now", 4'h0, 2'd0, 1'b0);
    step();
    check_out("arst_hold", 4'h0, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check_out("arst_rel0", HAS_SCAN ? 4'h1 : 4'h2, HAS_SCAN ? 2'd0 : 2'd1, 1'b0);
    step();
    check_out("arst_rel1", 4'h2, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
